// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU interface: default widths, opcode
// constants and the command-driver state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'b010;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Command-to-ALU initiator: registers a command onto the ALU inputs, waits a
// settle interval, then returns the sampled result over a valid/ready channel.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int OPW           = ALU_OPW,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_OPCODE    = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_opperand_1,
  output logic [WIDTH-1:0] alu_opperand_2,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [OPW-1:0]   rsp_opcode,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [OPW-1:0]   MAX_OP      = OPW'(MAX_OPCODE);

  drv_state_t       state_q;
  logic [SET_W-1:0] settle_q;
  logic [WIDTH-1:0] opnd1_q;
  logic [WIDTH-1:0] opnd2_q;
  logic [OPW-1:0]   aluop_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [OPW-1:0]   rsp_opcode_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] op_count_q;

  // Illegal opcodes skip the ALU entirely and answer with an error on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      opnd1_q      <= '0;
      opnd2_q      <= '0;
      aluop_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rsp_opcode_q <= cmd_opcode;
            if (cmd_opcode <= MAX_OP) begin
              opnd1_q  <= cmd_a;
              opnd2_q  <= cmd_b;
              aluop_q  <= cmd_opcode;
              settle_q <= SETTLE_LOAD;
              state_q  <= DRIVE;
            end else begin
              rsp_result_q <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        DRIVE: begin
          if (settle_q == '0) begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE) && !reset;
  assign busy           = (state_q != IDLE);
  assign alu_opperand_1 = opnd1_q;
  assign alu_opperand_2 = opnd2_q;
  assign alu_opcode     = aluop_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_opcode     = rsp_opcode_q;
  assign rsp_err        = rsp_err_q;
  assign op_count       = op_count_q;

endmodule
